rv0_wbu_rob: RTL and testbench
==============================

// Module: rv0_wbu_rob
// PURPOSE
//  Reorder-buffered write-back unit. Issue allocates a tag per instruction in program order.
//  EXU_CNT execution units complete out of order by tag. Entries commit in order, one per cycle,
//  to the integer/FP register files. A committed taken control transfer flushes all younger entries.
//  Sits between the EXUs and the register files; replaces the round-robin WBU when ZICSR=1.
// PARAMETERS
//  XLEN       32  integer datapath width
//  FLEN       32  FP register width, FLEN<=XLEN; FP data travels in cmp_data_i[FLEN-1:0]
//  EXU_CNT    4   completion channels, >=1
//  ROB_DEPTH  8   entries, power of two, >=2; TW=$clog2(ROB_DEPTH) (local)
// PORTS
//  clk_i         in   1            clock
//  rst_ni        in   1            async active-low reset
//  alloc_vld_i   in   1            issue requests an entry
//  alloc_rdy_o   out  1            entry available; alloc fires on vld&rdy
//  alloc_tag_o   out  TW           tag granted (tail index)
//  alloc_we_i    in   1            instruction writes a register
//  alloc_fp_i    in   1            0=integer RF, 1=FP RF
//  alloc_rd_i    in   5            destination register
//  cmp_vld_i     in   EXU_CNT      completion strobe per EXU
//  cmp_tag_i     in   EXU_CNT*TW   completing tag
//  cmp_data_i    in   EXU_CNT*XLEN result
//  cmp_ct_i      in   EXU_CNT      taken control transfer (JAL/JALR/taken BRANCH)
//  cmp_target_i  in   EXU_CNT*XLEN transfer target
//  rfi_we_o/rfi_waddr_o/rfi_wdata_o  out 1/5/XLEN  integer write-back
//  rff_we_o/rff_waddr_o/rff_wdata_o  out 1/5/FLEN  FP write-back
//  ct_trans_o    out  1            control transfer pulse
//  ct_target_o   out  XLEN         transfer target
//  flush_o       out  1            EXUs drop all in-flight work (same cycle as ct_trans_o)
//  empty_o       out  1            no allocated entries
// BEHAVIOUR
//  - Reset: head=tail=0, all entry valid/done=0; every output 0 except alloc_rdy_o=1, empty_o=1.
//  - Pointers TW+1 bits (wrap bit); empty: head==tail; full: indices equal, wrap bits differ.
//  - alloc_rdy_o = !full && !(head_done && head_ct). Not relaxed by a same-cycle commit.
//  - Alloc: entry[tail] <= {valid=1,done=0,we,fp,rd}, tail++; alloc_tag_o = tail[TW-1:0].
//  - Completion: entry[tag].done/data/ct/target written at the edge. A tag that is not valid is
//    ignored (assertion). Two channels hitting the same tag in one cycle is illegal (assertion).
//  - Commit: when head entry valid&done at an edge: head++, entry cleared, and output regs loaded.
//    Outputs are a single-cycle pulse. Completion at edge k -> entry done after k;
//    commit/outputs visible after edge k+1 (2-cycle latency).
//  - rfi_we_o=we&!fp&(rd!=0); rff_we_o=we&fp; wdata = stored data (FP uses low FLEN bits).
//  - ct_trans_o=stored ct; ct_target_o=stored target; flush_o=stored ct. Targets are zeroed when
//    not pulsing.
//  - Flush: commit of a ct entry at edge e -> tail<=head+1 and all entries invalidated at e.
//    Alloc cannot fire at e (rdy low). Completions sampled at e are discarded.
//  - Head completes at the same edge it is allocated: not possible (done lands next edge).
//  - Alloc and commit at the same edge: both apply; the count is unchanged.
//  - Mid-operation reset: all state and outputs return to reset values immediately (async).
//  - Commit is never stalled; the RFs always accept.
// STRUCTURE
//  - rv0_core_pkg: rob_entry_t {valid,done,we,fp,rd[4:0],ct,data,target}; TW as localparam.
//  - Sub-module rv0_rob_ptr: TW+1-bit wrapping pointer with inc and load; used for head and tail.
//  - Entry array is flops (no SRAM); completion write-enable decoded per entry per channel.
// TESTING
//  - Reset: check alloc_rdy_o=1, empty_o=1, all we/ct/flush=0. Assert rst_ni low mid-burst:
//    outputs zero the same cycle.
//  - In order: alloc x1,x2,x3 (tags 0,1,2); complete 0,1,2 in consecutive cycles (data 'h11,'h22,
//    'h33) -> rfi writes x1='h11, x2='h22, x3='h33 on consecutive cycles, 2 cycles after each
//    completion.
//  - Reorder: alloc tags 0..3; complete 3,2,1 then 0 -> no write until tag 0 completes, then 4
//    writes on back-to-back cycles in order 0,1,2,3.
//  - Full/wrap: DEPTH=8; alloc 8 -> alloc_rdy_o=0. Commit 1 -> rdy=1; next alloc_tag_o=0 with the
//    wrap bit toggled. Repeat over 3 wraps.
//  - Flush: alloc tags 0(JAL x1),1,2; complete 1,2 then 0 with ct=1, target='h80 -> rfi x1 write;
//    ct_trans_o=flush_o=1, ct_target_o='h80. Tags 1,2 never written. empty_o=1 next cycle.
//  - Multi-channel: EXU_CNT=4; all 4 complete distinct tags in one cycle -> 4 in-order commits.
//    rd=0 integer and we=0 entries commit with rfi_we_o=0; FP entry drives rff_we_o only.

Source files
------------

// File: rtl/rv0_core_pkg.sv
// Shared types for the reorder-buffered write-back path.
// Entry fields are sized for the default core configuration (32-bit data, 8-entry ROB).
package rv0_core_pkg;

   localparam int RV_XLEN      = 32;
   localparam int RV_ROB_DEPTH = 8;
   localparam int RV_TW        = $clog2(RV_ROB_DEPTH);

   typedef struct packed {
      logic               valid;
      logic               done;
      logic               we;
      logic               fp;
      logic [4:0]         rd;
      logic               ct;
      logic [RV_XLEN-1:0] data;
      logic [RV_XLEN-1:0] target;
   } rob_entry_t;

endpackage

// File: rtl/rv0_rob_ptr.sv
// Wrapping ROB pointer: TW index bits plus one wrap bit, with increment and parallel load.
module rv0_rob_ptr #(
   parameter int TW = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        i_inc,
   input  logic        i_load,
   input  logic [TW:0] i_load_val,
   output logic [TW:0] o_ptr
);

   logic [TW:0] r_ptr;

   // Load wins over increment so a flush can rewind the pointer in one edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr <= '0;
      end else if (i_load) begin
         r_ptr <= i_load_val;
      end else if (i_inc) begin
         r_ptr <= r_ptr + (TW+1)'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/rv0_wbu_rob.sv
// Reorder-buffered write-back unit: in-order allocate, out-of-order complete, in-order commit
// to the integer/FP register files, with flush of younger entries on a committed taken transfer.
module rv0_wbu_rob
   import rv0_core_pkg::*;
#(
   parameter  int XLEN      = RV_XLEN,
   parameter  int FLEN      = 32,
   parameter  int EXU_CNT   = 4,
   parameter  int ROB_DEPTH = RV_ROB_DEPTH,
   localparam int TW        = $clog2(ROB_DEPTH)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    alloc_vld_i,
   output logic                    alloc_rdy_o,
   output logic [TW-1:0]           alloc_tag_o,
   input  logic                    alloc_we_i,
   input  logic                    alloc_fp_i,
   input  logic [4:0]              alloc_rd_i,
   input  logic [EXU_CNT-1:0]      cmp_vld_i,
   input  logic [EXU_CNT*TW-1:0]   cmp_tag_i,
   input  logic [EXU_CNT*XLEN-1:0] cmp_data_i,
   input  logic [EXU_CNT-1:0]      cmp_ct_i,
   input  logic [EXU_CNT*XLEN-1:0] cmp_target_i,
   output logic                    rfi_we_o,
   output logic [4:0]              rfi_waddr_o,
   output logic [XLEN-1:0]         rfi_wdata_o,
   output logic                    rff_we_o,
   output logic [4:0]              rff_waddr_o,
   output logic [FLEN-1:0]         rff_wdata_o,
   output logic                    ct_trans_o,
   output logic [XLEN-1:0]         ct_target_o,
   output logic                    flush_o,
   output logic                    empty_o
);

   logic [TW:0]          w_head;
   logic [TW:0]          w_tail;
   logic [TW:0]          w_headNext;
   logic [TW-1:0]        w_headIdx;
   logic [TW-1:0]        w_tailIdx;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_commit;
   logic                 w_flush;
   logic                 w_alloc;
   logic                 w_rfiWe;
   logic                 w_rffWe;
   rob_entry_t           w_headEnt;
   rob_entry_t           w_newEnt;
   logic [ROB_DEPTH-1:0] w_validVec;
   logic [EXU_CNT-1:0]   w_hit [ROB_DEPTH];

   rob_entry_t           r_ent [ROB_DEPTH];
   logic                 r_rfiWe;
   logic [4:0]           r_rfiWaddr;
   logic [XLEN-1:0]      r_rfiWdata;
   logic                 r_rffWe;
   logic [4:0]           r_rffWaddr;
   logic [FLEN-1:0]      r_rffWdata;
   logic                 r_ct;
   logic [XLEN-1:0]      r_ctTarget;

   rv0_rob_ptr #(.TW(TW)) u_head (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_inc      (w_commit),
      .i_load     (1'b0),
      .i_load_val ('0),
      .o_ptr      (w_head)
   );

   rv0_rob_ptr #(.TW(TW)) u_tail (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_inc      (w_alloc),
      .i_load     (w_flush),
      .i_load_val (w_headNext),
      .o_ptr      (w_tail)
   );

   assign w_headIdx  = w_head[TW-1:0];
   assign w_tailIdx  = w_tail[TW-1:0];
   assign w_headNext = w_head + (TW+1)'(1);
   assign w_empty    = (w_head == w_tail);
   assign w_full     = (w_headIdx == w_tailIdx) && (w_head[TW] != w_tail[TW]);
   assign w_headEnt  = r_ent[w_headIdx];
   assign w_commit   = w_headEnt.valid && w_headEnt.done;
   assign w_flush    = w_commit && w_headEnt.ct;
   assign w_rfiWe    = w_commit && w_headEnt.we && !w_headEnt.fp && (w_headEnt.rd != 5'd0);
   assign w_rffWe    = w_commit && w_headEnt.we && w_headEnt.fp;

   // A completed control transfer at the head blocks issue so nothing is allocated under a flush.
   assign alloc_rdy_o = !w_full && !(w_headEnt.done && w_headEnt.ct);
   assign w_alloc     = alloc_vld_i && alloc_rdy_o;
   assign alloc_tag_o = w_tailIdx;
   assign empty_o     = w_empty;

   always_comb begin
      w_newEnt       = '0;
      w_newEnt.valid = 1'b1;
      w_newEnt.we    = alloc_we_i;
      w_newEnt.fp    = alloc_fp_i;
      w_newEnt.rd    = alloc_rd_i;
      for (int i = 0; i < ROB_DEPTH; i++) begin
         w_validVec[i] = r_ent[i].valid;
         w_hit[i]      = '0;
         for (int c = 0; c < EXU_CNT; c++) begin
            w_hit[i][c] = cmp_vld_i[c] && r_ent[i].valid && (cmp_tag_i[c*TW +: TW] == TW'(i));
         end
      end
   end

   // Entry updates: completion, then commit clear, then allocation; a flush clears everything.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ROB_DEPTH; i++) r_ent[i] <= '0;
      end else if (w_flush) begin
         for (int i = 0; i < ROB_DEPTH; i++) r_ent[i] <= '0;
      end else begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            for (int c = 0; c < EXU_CNT; c++) begin
               if (w_hit[i][c]) begin
                  r_ent[i].done   <= 1'b1;
                  r_ent[i].ct     <= cmp_ct_i[c];
                  r_ent[i].data   <= cmp_data_i[c*XLEN +: XLEN];
                  r_ent[i].target <= cmp_target_i[c*XLEN +: XLEN];
               end
            end
            if (w_commit && (w_headIdx == TW'(i))) r_ent[i] <= '0;
            if (w_alloc && (w_tailIdx == TW'(i)))  r_ent[i] <= w_newEnt;
         end
      end
   end

   // Write-back and redirect outputs pulse for exactly one cycle per commit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rfiWe    <= 1'b0;
         r_rfiWaddr <= '0;
         r_rfiWdata <= '0;
         r_rffWe    <= 1'b0;
         r_rffWaddr <= '0;
         r_rffWdata <= '0;
         r_ct       <= 1'b0;
         r_ctTarget <= '0;
      end else begin
         r_rfiWe    <= w_rfiWe;
         r_rfiWaddr <= w_rfiWe ? w_headEnt.rd : 5'd0;
         r_rfiWdata <= w_rfiWe ? w_headEnt.data : '0;
         r_rffWe    <= w_rffWe;
         r_rffWaddr <= w_rffWe ? w_headEnt.rd : 5'd0;
         r_rffWdata <= w_rffWe ? w_headEnt.data[FLEN-1:0] : '0;
         r_ct       <= w_flush;
         r_ctTarget <= w_flush ? w_headEnt.target : '0;
      end
   end

   assign rfi_we_o    = r_rfiWe;
   assign rfi_waddr_o = r_rfiWaddr;
   assign rfi_wdata_o = r_rfiWdata;
   assign rff_we_o    = r_rffWe;
   assign rff_waddr_o = r_rffWaddr;
   assign rff_wdata_o = r_rffWdata;
   assign ct_trans_o  = r_ct;
   assign ct_target_o = r_ctTarget;
   assign flush_o     = r_ct;

   // Completions must name a live entry, and no two channels may finish the same tag together.
   for (genvar gc = 0; gc < EXU_CNT; gc++) begin : g_cmpChk
      a_liveTag: assert property (@(posedge clk_i) disable iff (!rst_ni)
         cmp_vld_i[gc] |-> w_validVec[cmp_tag_i[gc*TW +: TW]]);
      for (genvar gd = gc + 1; gd < EXU_CNT; gd++) begin : g_pair
         a_uniqTag: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(cmp_vld_i[gc] && cmp_vld_i[gd] && (cmp_tag_i[gc*TW +: TW] == cmp_tag_i[gd*TW +: TW])));
      end
   end

endmodule

// File: tb/tb_rv0_wbu_rob.sv
// Bench for rv0_wbu_rob: directed scenarios plus a randomized run against a queue-based
// program-order model of the reorder buffer.
module tb_rv0_wbu_rob;

   localparam int XLEN = 32;
   localparam int FLEN = 32;
   localparam int EXU  = 4;
   localparam int D    = 8;
   localparam int TW   = 3;

   logic                clk_i = 1'b0;
   logic                rst_ni = 1'b0;
   logic                alloc_vld_i = 1'b0;
   logic                alloc_rdy_o;
   logic [TW-1:0]       alloc_tag_o;
   logic                alloc_we_i = 1'b0;
   logic                alloc_fp_i = 1'b0;
   logic [4:0]          alloc_rd_i = '0;
   logic [EXU-1:0]      cmp_vld_i = '0;
   logic [EXU*TW-1:0]   cmp_tag_i = '0;
   logic [EXU*XLEN-1:0] cmp_data_i = '0;
   logic [EXU-1:0]      cmp_ct_i = '0;
   logic [EXU*XLEN-1:0] cmp_target_i = '0;
   logic                rfi_we_o;
   logic [4:0]          rfi_waddr_o;
   logic [XLEN-1:0]     rfi_wdata_o;
   logic                rff_we_o;
   logic [4:0]          rff_waddr_o;
   logic [FLEN-1:0]     rff_wdata_o;
   logic                ct_trans_o;
   logic [XLEN-1:0]     ct_target_o;
   logic                flush_o;
   logic                empty_o;

   rv0_wbu_rob #(.XLEN(XLEN), .FLEN(FLEN), .EXU_CNT(EXU), .ROB_DEPTH(D)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .alloc_vld_i(alloc_vld_i), .alloc_rdy_o(alloc_rdy_o), .alloc_tag_o(alloc_tag_o),
      .alloc_we_i(alloc_we_i), .alloc_fp_i(alloc_fp_i), .alloc_rd_i(alloc_rd_i),
      .cmp_vld_i(cmp_vld_i), .cmp_tag_i(cmp_tag_i), .cmp_data_i(cmp_data_i),
      .cmp_ct_i(cmp_ct_i), .cmp_target_i(cmp_target_i),
      .rfi_we_o(rfi_we_o), .rfi_waddr_o(rfi_waddr_o), .rfi_wdata_o(rfi_wdata_o),
      .rff_we_o(rff_we_o), .rff_waddr_o(rff_waddr_o), .rff_wdata_o(rff_wdata_o),
      .ct_trans_o(ct_trans_o), .ct_target_o(ct_target_o), .flush_o(flush_o), .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   // Program-order model: one record per in-flight instruction, oldest first.
   typedef struct {
      int          tag;
      bit          we;
      bit          fp;
      logic [4:0]  rd;
      bit          done;
      logic [31:0] data;
      bit          ct;
      logic [31:0] target;
   } mEnt_t;

   mEnt_t mq[$];
   int    nextTag;
   int    nVec;
   int    nErr;

   bit          aVld, aWe, aFp;
   logic [4:0]  aRd;
   bit          cVld [EXU];
   int          cTag [EXU];
   logic [31:0] cData [EXU];
   bit          cCt [EXU];
   logic [31:0] cTgt [EXU];

   bit          eRfiWe, eRffWe, eCt, eEmpty, eRdy;
   logic [4:0]  eRfiAddr, eRffAddr;
   logic [31:0] eRfiData, eRffData, eTgt;
   int          eTag;

   function automatic bit modelRdy();
      return (mq.size() < D) && !((mq.size() > 0) && mq[0].done && mq[0].ct);
   endfunction

   task automatic clearStim();
      aVld = 0; aWe = 0; aFp = 0; aRd = '0;
      for (int c = 0; c < EXU; c++) begin
         cVld[c] = 0; cTag[c] = 0; cData[c] = '0; cCt[c] = 0; cTgt[c] = '0;
      end
   endtask

   task automatic driveInputs();
      alloc_vld_i = aVld; alloc_we_i = aWe; alloc_fp_i = aFp; alloc_rd_i = aRd;
      for (int c = 0; c < EXU; c++) begin
         cmp_vld_i[c] = cVld[c];
         cmp_ct_i[c]  = cCt[c];
         cmp_tag_i[c*TW +: TW]        = TW'(cTag[c]);
         cmp_data_i[c*XLEN +: XLEN]   = cData[c];
         cmp_target_i[c*XLEN +: XLEN] = cTgt[c];
      end
   endtask

   task automatic stimAlloc(input bit we, input bit fp, input logic [4:0] rd);
      aVld = 1; aWe = we; aFp = fp; aRd = rd;
   endtask

   task automatic stimCmp(input int ch, input int tag, input logic [31:0] data,
                          input bit ct, input logic [31:0] tgt);
      cVld[ch] = 1; cTag[ch] = tag; cData[ch] = data; cCt[ch] = ct; cTgt[ch] = tgt;
   endtask

   // One clock: drive the staged stimulus, let the edge happen, advance the model, settle.
   task automatic step();
      bit    preRdy, commit, flush;
      mEnt_t h, t;
      preRdy = modelRdy();
      driveInputs();
      @(posedge clk_i);
      commit = (mq.size() > 0) && mq[0].done;
      flush  = commit && mq[0].ct;
      eRfiWe = 0; eRffWe = 0; eCt = 0; eTgt = '0;
      eRfiAddr = '0; eRfiData = '0; eRffAddr = '0; eRffData = '0;
      if (!flush) begin
         for (int c = 0; c < EXU; c++) begin
            if (cVld[c]) begin
               foreach (mq[k]) begin
                  if (mq[k].tag == cTag[c]) begin
                     t = mq[k]; t.done = 1; t.data = cData[c]; t.ct = cCt[c]; t.target = cTgt[c];
                     mq[k] = t;
                  end
               end
            end
         end
      end
      if (commit) begin
         h = mq.pop_front();
         eRfiWe = h.we && !h.fp && (h.rd != 0);
         eRffWe = h.we && h.fp;
         if (eRfiWe) begin eRfiAddr = h.rd; eRfiData = h.data; end
         if (eRffWe) begin eRffAddr = h.rd; eRffData = h.data; end
         if (flush) begin
            eCt = 1; eTgt = h.target;
            mq.delete();
            nextTag = (h.tag + 1) % D;
         end
      end
      if (aVld && preRdy) begin
         t.tag = nextTag; t.we = aWe; t.fp = aFp; t.rd = aRd;
         t.done = 0; t.data = '0; t.ct = 0; t.target = '0;
         mq.push_back(t);
         nextTag = (nextTag + 1) % D;
      end
      #1;
      eEmpty = (mq.size() == 0);
      eRdy   = modelRdy();
      eTag   = nextTag;
   endtask

   task automatic hardReset();
      rst_ni = 0;
      clearStim();
      driveInputs();
      @(negedge clk_i);
      mq.delete();
      nextTag = 0;
      @(negedge clk_i);
      rst_ni = 1;
   endtask

   task automatic test_reset();
      rst_ni = 0;
      clearStim();
      driveInputs();
      repeat (2) @(posedge clk_i);
      #1;
      nVec++; if (alloc_rdy_o !== 1'b1) begin nErr++; $display("FAIL reset_rdy: got %0b want 1", alloc_rdy_o); end
      nVec++; if (empty_o !== 1'b1) begin nErr++; $display("FAIL reset_empty: got %0b want 1", empty_o); end
      nVec++; if (alloc_tag_o !== 3'd0) begin nErr++; $display("FAIL reset_tag: got %0d want 0", alloc_tag_o); end
      nVec++; if ({rfi_we_o, rff_we_o, ct_trans_o, flush_o} !== 4'b0) begin nErr++; $display("FAIL reset_pulses: got %b want 0000", {rfi_we_o, rff_we_o, ct_trans_o, flush_o}); end
      nVec++; if (ct_target_o !== 32'd0) begin nErr++; $display("FAIL reset_target: got %0h want 0", ct_target_o); end
      @(negedge clk_i);
      mq.delete();
      nextTag = 0;
      rst_ni = 1;
   endtask

   task automatic test_in_order();
      logic [31:0] d [3];
      d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
      hardReset();
      for (int i = 0; i < 3; i++) begin
         nVec++; if (alloc_tag_o !== 3'(i)) begin nErr++; $display("FAIL inorder_tag%0d: got %0d want %0d", i, alloc_tag_o, i); end
         clearStim(); stimAlloc(1, 0, 5'(i + 1)); step();
      end
      for (int i = 0; i < 4; i++) begin
         clearStim();
         if (i < 3) stimCmp(0, i, d[i], 0, '0);
         step();
         if (i == 0) begin
            nVec++; if (rfi_we_o !== 1'b0) begin nErr++; $display("FAIL inorder_early: got %0b want 0", rfi_we_o); end
         end else begin
            nVec++; if (rfi_we_o !== 1'b1 || rfi_waddr_o !== 5'(i) || rfi_wdata_o !== d[i-1])
               begin nErr++; $display("FAIL inorder_wb%0d: got we=%0b x%0d=%0h want we=1 x%0d=%0h", i, rfi_we_o, rfi_waddr_o, rfi_wdata_o, i, d[i-1]); end
         end
      end
      nVec++; if (empty_o !== 1'b1) begin nErr++; $display("FAIL inorder_empty: got %0b want 1", empty_o); end
   endtask

   task automatic test_reorder();
      logic [31:0] d [4];
      hardReset();
      for (int i = 0; i < 4; i++) begin
         d[i] = $urandom;
         clearStim(); stimAlloc(1, 0, 5'(10 + i)); step();
      end
      for (int i = 3; i >= 0; i--) begin
         clearStim(); stimCmp(i % EXU, i, d[i], 0, '0); step();
         nVec++; if (rfi_we_o !== 1'b0) begin nErr++; $display("FAIL reorder_hold%0d: got %0b want 0", i, rfi_we_o); end
      end
      for (int k = 0; k < 4; k++) begin
         clearStim(); step();
         nVec++; if (rfi_we_o !== 1'b1 || rfi_waddr_o !== 5'(10 + k) || rfi_wdata_o !== d[k])
            begin nErr++; $display("FAIL reorder_wb%0d: got we=%0b x%0d=%0h want we=1 x%0d=%0h", k, rfi_we_o, rfi_waddr_o, rfi_wdata_o, 10 + k, d[k]); end
      end
   endtask

   task automatic test_full_wrap();
      int h;
      hardReset();
      for (int i = 0; i < D; i++) begin
         clearStim(); stimAlloc(1, 0, 5'(i + 1)); step();
      end
      nVec++; if (alloc_rdy_o !== 1'b0) begin nErr++; $display("FAIL full_rdy: got %0b want 0", alloc_rdy_o); end
      nVec++; if (empty_o !== 1'b0) begin nErr++; $display("FAIL full_empty: got %0b want 0", empty_o); end
      for (int w = 0; w < 3 * D; w++) begin
         h = w % D;
         clearStim(); stimCmp(w % EXU, h, $urandom, 0, '0); stimAlloc(1, 0, 5'd4); step();
         nVec++; if (alloc_rdy_o !== 1'b0 || alloc_tag_o !== 3'(h)) begin nErr++; $display("FAIL wrap_stillfull%0d: got rdy=%0b tag=%0d want rdy=0 tag=%0d", w, alloc_rdy_o, alloc_tag_o, h); end
         clearStim(); step();
         nVec++; if (alloc_rdy_o !== 1'b1 || alloc_tag_o !== 3'(h)) begin nErr++; $display("FAIL wrap_free%0d: got rdy=%0b tag=%0d want rdy=1 tag=%0d", w, alloc_rdy_o, alloc_tag_o, h); end
         clearStim(); stimAlloc(1, 0, 5'd6); step();
         nVec++; if (alloc_rdy_o !== 1'b0) begin nErr++; $display("FAIL wrap_refill%0d: got %0b want 0", w, alloc_rdy_o); end
      end
   endtask

   task automatic test_flush();
      hardReset();
      for (int i = 0; i < 3; i++) begin
         clearStim(); stimAlloc(1, 0, 5'(i + 1)); step();
      end
      clearStim(); stimCmp(1, 1, 32'hAAAA, 0, '0); step();
      clearStim(); stimCmp(2, 2, 32'hBBBB, 0, '0); step();
      clearStim(); stimCmp(0, 0, 32'h104, 1, 32'h80); step();
      nVec++; if (alloc_rdy_o !== 1'b0) begin nErr++; $display("FAIL flush_rdyblock: got %0b want 0", alloc_rdy_o); end
      clearStim(); stimAlloc(1, 0, 5'd9); step();
      nVec++; if (rfi_we_o !== 1'b1 || rfi_waddr_o !== 5'd1 || rfi_wdata_o !== 32'h104)
         begin nErr++; $display("FAIL flush_link: got we=%0b x%0d=%0h want we=1 x1=104", rfi_we_o, rfi_waddr_o, rfi_wdata_o); end
      nVec++; if (ct_trans_o !== 1'b1 || flush_o !== 1'b1 || ct_target_o !== 32'h80)
         begin nErr++; $display("FAIL flush_redirect: got ct=%0b fl=%0b tgt=%0h want 1 1 80", ct_trans_o, flush_o, ct_target_o); end
      nVec++; if (empty_o !== 1'b1 || alloc_tag_o !== 3'd1) begin nErr++; $display("FAIL flush_state: got empty=%0b tag=%0d want 1 1", empty_o, alloc_tag_o); end
      for (int k = 0; k < 2; k++) begin
         clearStim(); step();
         nVec++; if ({rfi_we_o, ct_trans_o, flush_o} !== 3'b0 || ct_target_o !== 32'd0)
            begin nErr++; $display("FAIL flush_quiet%0d: got we/ct/fl=%b tgt=%0h want 000 0", k, {rfi_we_o, ct_trans_o, flush_o}, ct_target_o); end
      end
   endtask

   task automatic test_multi();
      bit         aw [4];
      bit         af [4];
      logic [4:0] ar [4];
      bit         xRfi [4];
      bit         xRff [4];
      aw[0] = 1; af[0] = 0; ar[0] = 5'd0; xRfi[0] = 0; xRff[0] = 0;
      aw[1] = 0; af[1] = 0; ar[1] = 5'd5; xRfi[1] = 0; xRff[1] = 0;
      aw[2] = 1; af[2] = 1; ar[2] = 5'd7; xRfi[2] = 0; xRff[2] = 1;
      aw[3] = 1; af[3] = 0; ar[3] = 5'd9; xRfi[3] = 1; xRff[3] = 0;
      hardReset();
      for (int i = 0; i < 4; i++) begin
         clearStim(); stimAlloc(aw[i], af[i], ar[i]); step();
      end
      clearStim();
      for (int c = 0; c < EXU; c++) stimCmp(c, 3 - c, 32'hA0 + 32'(3 - c), 0, '0);
      step();
      for (int k = 0; k < 4; k++) begin
         clearStim(); step();
         nVec++; if (rfi_we_o !== xRfi[k] || rff_we_o !== xRff[k])
            begin nErr++; $display("FAIL multi_we%0d: got rfi=%0b rff=%0b want %0b %0b", k, rfi_we_o, rff_we_o, xRfi[k], xRff[k]); end
         if (xRfi[k]) begin
            nVec++; if (rfi_waddr_o !== ar[k] || rfi_wdata_o !== 32'hA0 + 32'(k)) begin nErr++; $display("FAIL multi_rfi%0d: got x%0d=%0h want x%0d=%0h", k, rfi_waddr_o, rfi_wdata_o, ar[k], 32'hA0 + 32'(k)); end
         end
         if (xRff[k]) begin
            nVec++; if (rff_waddr_o !== ar[k] || rff_wdata_o !== 32'hA0 + 32'(k)) begin nErr++; $display("FAIL multi_rff%0d: got f%0d=%0h want f%0d=%0h", k, rff_waddr_o, rff_wdata_o, ar[k], 32'hA0 + 32'(k)); end
         end
      end
      nVec++; if (empty_o !== 1'b1) begin nErr++; $display("FAIL multi_empty: got %0b want 1", empty_o); end
   endtask

   task automatic test_random();
      int cand[$];
      int idx;
      for (int n = 0; n < 2000; n++) begin
         clearStim();
         if ($urandom_range(0, 99) < 60) stimAlloc(1'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom));
         cand.delete();
         foreach (mq[k]) if (!mq[k].done) cand.push_back(mq[k].tag);
         for (int c = 0; c < EXU; c++) begin
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
               idx = $urandom_range(0, cand.size() - 1);
               stimCmp(c, cand[idx], $urandom, ($urandom_range(0, 19) == 0), $urandom);
               cand.delete(idx);
            end
         end
         step();
         nVec++; if (rfi_we_o !== eRfiWe) begin nErr++; $display("FAIL rnd_rfi_we c%0d: got %0b want %0b", n, rfi_we_o, eRfiWe); end
         if (eRfiWe) begin
            nVec++; if (rfi_waddr_o !== eRfiAddr || rfi_wdata_o !== eRfiData) begin nErr++; $display("FAIL rnd_rfi c%0d: got x%0d=%0h want x%0d=%0h", n, rfi_waddr_o, rfi_wdata_o, eRfiAddr, eRfiData); end
         end
         nVec++; if (rff_we_o !== eRffWe) begin nErr++; $display("FAIL rnd_rff_we c%0d: got %0b want %0b", n, rff_we_o, eRffWe); end
         if (eRffWe) begin
            nVec++; if (rff_waddr_o !== eRffAddr || rff_wdata_o !== eRffData) begin nErr++; $display("FAIL rnd_rff c%0d: got f%0d=%0h want f%0d=%0h", n, rff_waddr_o, rff_wdata_o, eRffAddr, eRffData); end
         end
         nVec++; if (ct_trans_o !== eCt || flush_o !== eCt || ct_target_o !== eTgt) begin nErr++; $display("FAIL rnd_ct c%0d: got ct=%0b fl=%0b tgt=%0h want %0b %0b %0h", n, ct_trans_o, flush_o, ct_target_o, eCt, eCt, eTgt); end
         nVec++; if (empty_o !== eEmpty || alloc_rdy_o !== eRdy || alloc_tag_o !== 3'(eTag)) begin nErr++; $display("FAIL rnd_state c%0d: got empty=%0b rdy=%0b tag=%0d want %0b %0b %0d", n, empty_o, alloc_rdy_o, alloc_tag_o, eEmpty, eRdy, eTag); end
      end
   endtask

   task automatic test_reset_mid();
      hardReset();
      clearStim(); stimAlloc(1, 0, 5'd5); step();
      clearStim(); stimAlloc(1, 0, 5'd6); step();
      clearStim(); stimCmp(0, 0, 32'hDEAD, 0, '0); step();
      clearStim(); step();
      nVec++; if (rfi_we_o !== 1'b1 || rfi_wdata_o !== 32'hDEAD) begin nErr++; $display("FAIL midrst_pre: got we=%0b d=%0h want 1 dead", rfi_we_o, rfi_wdata_o); end
      rst_ni = 0;
      #2;
      nVec++; if (rfi_we_o !== 1'b0 || rfi_waddr_o !== 5'd0 || rfi_wdata_o !== 32'd0) begin nErr++; $display("FAIL midrst_wb: got we=%0b x%0d=%0h want 0", rfi_we_o, rfi_waddr_o, rfi_wdata_o); end
      nVec++; if (empty_o !== 1'b1 || alloc_rdy_o !== 1'b1 || alloc_tag_o !== 3'd0) begin nErr++; $display("FAIL midrst_state: got empty=%0b rdy=%0b tag=%0d want 1 1 0", empty_o, alloc_rdy_o, alloc_tag_o); end
      clearStim();
      driveInputs();
      mq.delete();
      nextTag = 0;
      @(negedge clk_i);
      rst_ni = 1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares", nVec, nErr);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      nVec = 0;
      nErr = 0;
      nextTag = 0;
      clearStim();
      test_reset();
      test_in_order();
      test_reorder();
      test_full_wrap();
      test_flush();
      test_multi();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
